falu_arbiter: RTL

FALU_ARBITER -- requirements
Module: falu_arbiter

---
 rtl/falu_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/falu_arbiter.sv
// ---------------------------------------------------------------------------
// falu_arbiter
//
// Purpose:
//   Shares one combinational floatALU between two requesters. A round-robin
//   arbiter picks one requester in IDLE, the accepted operands are registered
//   onto the ALU port (EXEC), and the ALU outputs are captured into a response
//   register presented in RESP until the consumer accepts it. The carry-out
//   of each completed operation is fed back as carry-in for the next one.
//   Op codes and float fields pass through untouched; all float semantics
//   live in the external floatALU.
//
// Parameters:
//   WIDTH      total float word width
//   EXP_W      exponent field width (format description only)
//   MANTISSA_W mantissa field width (format description only)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester handshake (bit i = requester i)
//   req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op              packed op codes, requester i at [i*4 +: 4]
//   rsp_valid/rsp_ready response handshake
//   rsp_id              requester owning the response
//   rsp_result/rsp_flags captured ALU result and flags (flags[2] = carry-out)
//   alu_a/alu_b/alu_op  registered operands/op driven to the floatALU
//   alu_cin             registered carry-in (last captured carry-out)
//   alu_result/alu_flags floatALU outputs, combinational from alu_*
//   sticky_clr/sticky_flags  only with FALU_ARB_STICKY_EN: accumulated flags
//   dbg_state           current FSM state (IDLE=0, EXEC=1, RESP=2)
//
// Optional feature macro: FALU_ARB_STICKY_EN
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on ready; once rsp_valid is high the
// response (id, result, flags) is held until the transfer. req_ready is a
// combinational function of state, pointer and req_valid.
// ---------------------------------------------------------------------------
module falu_arbiter #(
    parameter int WIDTH      = 8,
    parameter int EXP_W      = 4,
    parameter int MANTISSA_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [7:0]         req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_result,
    output logic [2:0]         rsp_flags,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_op,
    output logic               alu_cin,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [2:0]         alu_flags,
`ifdef FALU_ARB_STICKY_EN
    input  logic               sticky_clr,
    output logic [2:0]         sticky_flags,
`endif
    output logic [1:0]         dbg_state
);

    // A sign bit plus the exponent and mantissa fields must fit in the word.
    if (WIDTH < EXP_W + MANTISSA_W + 1) begin : g_bad_format
        $error("falu_arbiter: WIDTH too small for EXP_W + MANTISSA_W + sign");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;          // last granted requester
    logic               rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic [2:0]         rsp_flags_q, rsp_flags_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic               alu_cin_q, alu_cin_d;

    logic               gnt_idx;
    logic               req_hs;
    logic               rsp_hs;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [3:0]         sel_op;

    // ---------------------------------------------------------------------
    // Round-robin grant: a lone valid requester wins; on a tie the one not
    // granted last wins. The pointer only moves on an actual handshake.
    // ---------------------------------------------------------------------
    always_comb begin
        gnt_idx   = 1'b0;
        req_ready = 2'b00;
        if (req_valid == 2'b11) begin
            gnt_idx = ~last_q;
        end else begin
            gnt_idx = req_valid[1];
        end
        if ((state_q == ST_IDLE) && req_valid[gnt_idx]) begin
            req_ready = gnt_idx ? 2'b10 : 2'b01;
        end
    end

    // req_ready is only ever set for a valid requester, so any ready bit
    // means a transfer this cycle.
    assign req_hs = |req_ready;
    assign rsp_hs = rsp_valid & rsp_ready;

    assign sel_a  = gnt_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign sel_b  = gnt_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    assign sel_op = gnt_idx ? req_op[7:4] : req_op[3:0];

    // ---------------------------------------------------------------------
    // FSM next state and datapath register loads
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_cin_d    = alu_cin_q;

        case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    state_d  = ST_EXEC;
                    last_d   = gnt_idx;
                    rsp_id_d = gnt_idx;
                    alu_a_d  = sel_a;
                    alu_b_d  = sel_b;
                    alu_op_d = sel_op;
                end
            end
            ST_EXEC: begin
                // The ALU has had a full cycle on stable registered inputs.
                state_d      = ST_RESP;
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                alu_cin_d    = alu_flags[2];
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;   // requester 0 wins the first tie
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= 3'b000;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 4'h0;
            alu_cin_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_cin_q    <= alu_cin_d;
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_cin    = alu_cin_q;
    assign dbg_state  = state_q;

`ifdef FALU_ARB_STICKY_EN
    // ---------------------------------------------------------------------
    // Sticky flags: accumulate flags of every delivered response; a clear
    // in the same cycle as a delivery wins.
    // ---------------------------------------------------------------------
    logic [2:0] sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr) begin
            sticky_d = 3'b000;
        end else if (rsp_hs) begin
            sticky_d = sticky_q | rsp_flags_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 3'b000;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule
